// File: rtl/accum_token_scheduler_pkg.sv
// Shared definitions for the accumulator token path: scheduler states and
// token field layout (also used by the accumulator core to decode tokens).
package accum_token_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_LEAP = 2'd2
  } sched_state_t;

  // Token layout, MSB first: leap, lst, [shift], sub, weights[nb*wd-1:0]
  function automatic int unsigned token_width(input int unsigned nb, input int unsigned wd,
                                              input bit rc);
    return nb * wd + (rc ? 32'd4 : 32'd3);
  endfunction

  function automatic int unsigned sub_bit(input int unsigned nb, input int unsigned wd);
    return nb * wd;
  endfunction

  function automatic int unsigned shift_bit(input int unsigned nb, input int unsigned wd);
    return nb * wd + 32'd1;
  endfunction

  function automatic int unsigned lst_bit(input int unsigned nb, input int unsigned wd,
                                          input bit rc);
    return token_width(nb, wd, rc) - 32'd2;
  endfunction

  function automatic int unsigned leap_bit(input int unsigned nb, input int unsigned wd,
                                           input bit rc);
    return token_width(nb, wd, rc) - 32'd1;
  endfunction

endpackage

// File: rtl/accum_token_scheduler_token_fifo2.sv
// Two-entry valid/ready FIFO holding outgoing tokens; head is presented
// directly so data stays stable while the consumer stalls.
module token_fifo2 #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];
  assign occ   = count;

  // The scheduler's credit accounting must never push into a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == 2'd2) && !do_pop));

endmodule

// File: rtl/accum_token_scheduler.sv
// Turns one frame of NA {en,sub} flags into a weight-token stream: one token
// per active input (last one marked lst), or a single leap token if none.
module accum_token_scheduler
  import accum_token_scheduler_pkg::*;
#(
  parameter int unsigned NA   = 4,
  parameter int unsigned NB   = 4,
  parameter int unsigned WD   = 2,
  parameter string       TYPE = "rc"
) (
  input  logic                                   iCLK,
  input  logic                                   iRST,
  input  logic                                   iValid_FR,
  output logic                                   oReady_FR,
  input  logic [2*NA-1:0]                        iData_FR,
  input  logic                                   iShift_FR,
  output logic                                   oRen_WM,
  output logic [((NA > 1) ? $clog2(NA) : 1)-1:0] oAddr_WM,
  input  logic [NB*WD-1:0]                       iData_WM,
  output logic                                   oValid_AS,
  input  logic                                   iReady_AS,
  output logic [token_width(NB, WD, (TYPE == "rc"))-1:0] oData_AS
);

  localparam bit          IS_RC   = (TYPE == "rc");
  localparam int unsigned AW      = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned WW      = NB * WD;
  localparam int unsigned TW      = token_width(NB, WD, IS_RC);
  localparam int unsigned LEAP_B  = leap_bit(NB, WD, IS_RC);
  localparam int unsigned LST_B   = lst_bit(NB, WD, IS_RC);
  localparam int unsigned SHIFT_B = shift_bit(NB, WD);
  localparam int unsigned SUB_B   = sub_bit(NB, WD);

  sched_state_t    state, state_d;
  logic [AW-1:0]   ptr, ptr_d, last_q, last_c;
  logic [NA-1:0]   en_q, sub_q, en_in, sub_in;
  logic            shift_q;
  logic            infl_q, tag_lst_q, tag_sub_q;
  logic            load, leap_push, pop_fire, credit;
  logic [2:0]      load_sum;
  logic [1:0]      occ;
  logic            fifo_push;
  logic [TW-1:0]   push_tok;

  // Unpack frame flags and find the highest active input
  always_comb begin
    en_in  = '0;
    sub_in = '0;
    last_c = '0;
    for (int i = 0; i < NA; i++) begin
      en_in[i]  = iData_FR[2*i+1];
      sub_in[i] = iData_FR[2*i];
      if (iData_FR[2*i+1]) last_c = AW'(i);
    end
  end

  // A token popped this cycle frees its slot, keeping 1 token/cycle streaming
  assign pop_fire = oValid_AS && iReady_AS;
  assign load_sum = 3'(occ) + 3'(infl_q) - 3'(pop_fire);
  assign credit   = (load_sum < 3'd2);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      en_q      <= '0;
      sub_q     <= '0;
      shift_q   <= 1'b0;
      last_q    <= '0;
      infl_q    <= 1'b0;
      tag_lst_q <= 1'b0;
      tag_sub_q <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      infl_q <= oRen_WM;
      if (load) begin
        en_q    <= en_in;
        sub_q   <= sub_in;
        shift_q <= iShift_FR;
        last_q  <= last_c;
      end
      if (oRen_WM) begin
        tag_lst_q <= (ptr == last_q);
        tag_sub_q <= sub_q[ptr];
      end
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    oReady_FR = 1'b0;
    oRen_WM   = 1'b0;
    oAddr_WM  = '0;
    load      = 1'b0;
    leap_push = 1'b0;
    unique case (state)
      ST_IDLE: begin
        oReady_FR = 1'b1;
        if (iValid_FR) begin
          load    = 1'b1;
          ptr_d   = '0;
          state_d = (|en_in) ? ST_SCAN : ST_LEAP;
        end
      end
      ST_SCAN: begin
        if (!en_q[ptr] || credit) begin
          if (en_q[ptr]) begin
            oRen_WM  = 1'b1;
            oAddr_WM = ptr;
          end
          if (ptr == last_q) state_d = ST_IDLE;
          else               ptr_d   = ptr + AW'(1);
        end
      end
      ST_LEAP: begin
        if ((occ < 2'd2) && !infl_q) begin
          leap_push = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Returning row data and the leap token never coincide (LEAP waits for no read in flight)
  always_comb begin
    push_tok = '0;
    if (infl_q) begin
      push_tok[WW-1:0] = iData_WM;
      push_tok[SUB_B]  = tag_sub_q;
      push_tok[LST_B]  = tag_lst_q;
    end else begin
      push_tok[LEAP_B] = 1'b1;
    end
    if (IS_RC) push_tok[SHIFT_B] = shift_q;
  end

  assign fifo_push = infl_q || leap_push;

  token_fifo2 #(.W(TW)) u_fifo (
    .clk       (iCLK),
    .rst       (iRST),
    .push      (fifo_push),
    .push_data (push_tok),
    .pop       (iReady_AS),
    .valid     (oValid_AS),
    .data      (oData_AS),
    .occ       (occ)
  );

endmodule

// File: tb/tb_accum_token_scheduler.sv
// Directed bench for accum_token_scheduler (NA=4, NB=4, WD=2, rc tokens).
module tb_accum_token_scheduler;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iValid_FR = 1'b0;
  logic        oReady_FR;
  logic [7:0]  iData_FR = '0;
  logic        iShift_FR = 1'b0;
  logic        oRen_WM;
  logic [1:0]  oAddr_WM;
  logic [7:0]  iData_WM = '0;
  logic        oValid_AS;
  logic        iReady_AS = 1'b1;
  logic [11:0] oData_AS;

  accum_token_scheduler #(.NA(4), .NB(4), .WD(2), .TYPE("rc")) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid_FR(iValid_FR), .oReady_FR(oReady_FR),
    .iData_FR(iData_FR), .iShift_FR(iShift_FR), .oRen_WM(oRen_WM), .oAddr_WM(oAddr_WM),
    .iData_WM(iData_WM), .oValid_AS(oValid_AS), .iReady_AS(iReady_AS), .oData_AS(oData_AS)
  );

  always #5 iCLK = ~iCLK;

  logic [7:0]  mem [4];
  initial begin
    mem[0] = 8'h1B; mem[1] = 8'h2C; mem[2] = 8'h3D; mem[3] = 8'h4E;
  end

  // Weight RAM model: one-cycle read latency
  always @(posedge iCLK) if (oRen_WM) iData_WM <= mem[oAddr_WM];

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          rd_cnt = 0;
  int          acc_cyc = 0;
  int          ren3_cyc = 0;
  logic [1:0]  last_addr = '0;
  logic [11:0] tq[$];
  int          tc[$];

  always @(posedge iCLK) cyc <= cyc + 1;

  // Observe transfers mid-cycle; each one completes at the next rising edge
  always @(negedge iCLK) if (!iRST) begin
    if (oValid_AS && iReady_AS) begin
      tq.push_back(oData_AS);
      tc.push_back(cyc);
    end
    if (oRen_WM) begin
      rd_cnt++;
      last_addr = oAddr_WM;
      if (oAddr_WM == 2'd3) ren3_cyc = cyc;
    end
    if (iValid_FR && oReady_FR) acc_cyc = cyc;
  end

  function automatic logic [11:0] tok(input logic leap, input logic lst, input logic sh,
                                      input logic sub, input logic [7:0] w);
    return {leap, lst, sh, sub, w};
  endfunction

  function automatic logic [31:0] qat(input int i);
    if (i < tq.size()) return 32'(tq[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cat(input int i);
    if (i < tc.size()) return tc[i];
    return -1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #2;
    end
  endtask

  task automatic clear();
    tq.delete();
    tc.delete();
    rd_cnt    = 0;
    last_addr = '0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sh, input string tag);
    int k;
    iData_FR  = d;
    iShift_FR = sh;
    iValid_FR = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge iCLK);
      if (oReady_FR) break;
    end
    chk({tag, "_accept"}, 32'(k < 40), 32'd1);
    step(1);
    iValid_FR = 1'b0;
  endtask

  task automatic wait_tokens(input int n, input string tag);
    int k;
    for (k = 0; k < 30; k++) begin
      if (tq.size() >= n) break;
      step(1);
    end
    chk({tag, "_arrive"}, 32'(tq.size() >= n), 32'd1);
    step(6);
    chk({tag, "_count"}, 32'(tq.size()), 32'(n));
  endtask

  initial begin : main
    int  k;
    bit  stable;

    // Reset state
    step(2);
    @(negedge iCLK);
    chk("rst_ready", 32'(oReady_FR), 32'd1);
    chk("rst_valid", 32'(oValid_AS), 32'd0);
    chk("rst_ren",   32'(oRen_WM),   32'd0);
    chk("rst_addr",  32'(oAddr_WM),  32'd0);
    step(1);
    iRST = 1'b0;
    step(1);

    // All four inputs active, sub=0101, streaming consumer
    clear();
    send_frame(8'hBB, 1'b1, "t1");
    wait_tokens(4, "t1");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_tok%0d", i), qat(i),
          32'(tok(1'b0, (i == 3), 1'b1, ((i % 2) == 0), mem[i])));
      chk($sformatf("t1_cyc%0d", i), 32'(cat(i) - cat(0)), 32'(i));
    end
    chk("t1_latency", 32'(cat(0) - acc_cyc), 32'd3);
    chk("t1_reads", 32'(rd_cnt), 32'd4);

    // Single active input 2
    clear();
    send_frame(8'h20, 1'b0, "t2");
    wait_tokens(1, "t2");
    chk("t2_tok", qat(0), 32'(tok(1'b0, 1'b1, 1'b0, 1'b0, mem[2])));
    chk("t2_reads", 32'(rd_cnt), 32'd1);
    chk("t2_addr", 32'(last_addr), 32'd2);

    // Empty frame -> leap token
    clear();
    send_frame(8'h00, 1'b1, "t3");
    wait_tokens(1, "t3");
    chk("t3_tok", qat(0), 32'h0000_0A00);
    chk("t3_reads", 32'(rd_cnt), 32'd0);

    // Consumer stalled 5 cycles from first valid
    clear();
    iReady_AS = 1'b0;
    send_frame(8'hAA, 1'b0, "t4");
    for (k = 0; k < 20; k++) begin
      @(negedge iCLK);
      if (oValid_AS) break;
    end
    chk("t4_first_valid", 32'(k < 20), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge iCLK);
      if (!(oValid_AS === 1'b1 && oData_AS === tok(1'b0, 1'b0, 1'b0, 1'b0, mem[0])))
        stable = 1'b0;
    end
    chk("t4_stable", 32'(stable), 32'd1);
    step(1);
    chk("t4_reads_stalled", 32'(rd_cnt <= 2), 32'd1);
    iReady_AS = 1'b1;
    wait_tokens(4, "t4");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_tok%0d", i), qat(i),
          32'(tok(1'b0, (i == 3), 1'b0, 1'b0, mem[i])));
    chk("t4_reads", 32'(rd_cnt), 32'd4);

    // Back-to-back frames 1010 then empty
    clear();
    send_frame(8'h88, 1'b1, "t5a");
    send_frame(8'h00, 1'b0, "t5b");
    wait_tokens(3, "t5");
    chk("t5_tok0", qat(0), 32'(tok(1'b0, 1'b0, 1'b1, 1'b0, mem[1])));
    chk("t5_tok1", qat(1), 32'(tok(1'b0, 1'b1, 1'b1, 1'b0, mem[3])));
    chk("t5_tok2", qat(2), 32'h0000_0800);
    chk("t5_ready_back", 32'(acc_cyc - ren3_cyc), 32'd1);
    chk("t5_reads", 32'(rd_cnt), 32'd2);

    // Reset while scanning with a read in flight
    clear();
    send_frame(8'hFF, 1'b0, "t6");
    step(1);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("t6_rst_valid", 32'(oValid_AS), 32'd0);
    chk("t6_rst_ready", 32'(oReady_FR), 32'd1);
    chk("t6_rst_ren",   32'(oRen_WM),   32'd0);
    step(1);
    iRST = 1'b0;
    clear();
    send_frame(8'h02, 1'b0, "t6b");
    wait_tokens(1, "t6b");
    chk("t6_tok", qat(0), 32'(tok(1'b0, 1'b1, 1'b0, 1'b0, mem[0])));
    chk("t6_reads", 32'(rd_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
